// File: rtl/tomasulo_dbg_pkg.sv
// Shared debug-path types: register index, register count and selector FSM states,
// plus the wrap-around index step used by the selector.
package tomasulo_dbg_pkg;

   typedef logic [4:0] reg_idx_t;

   localparam int NUM_ARCH_REGS = 32;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } sel_state_t;

   function automatic reg_idx_t step_idx(input reg_idx_t idx, input logic up, input int num_regs);
      reg_idx_t last;
      last = reg_idx_t'(num_regs - 1);
      if (up) return (idx == last) ? reg_idx_t'(0) : idx + 5'd1;
      else    return (idx == '0)   ? last           : idx - 5'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level plus one-cycle rise strobe, DEBOUNCE_CYCLES+2 after a clean edge.
// No backpressure; a button already held when reset releases gives no rise until it is released and pressed again.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [1:0]       sync_vld;
   logic             armed;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             settle;

   assign differ = (sync2 != level);
   assign settle = differ && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync_vld <= 2'b00;
         armed    <= 1'b0;
         cnt      <= '0;
         level    <= 1'b0;
         rise     <= 1'b0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
         // Arm only once real synchronised data has shown the button released.
         armed    <= armed | (sync_vld[1] & ~sync2 & ~level);
         rise     <= settle & ~level & armed;
         if (settle) begin
            level <= ~level;
            cnt   <= '0;
         end else if (differ) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/reg_select_ctrl.sv
// Up/down/zero buttons -> wrapping register index with hold-to-repeat; steps one cycle after a press strobe.
// No backpressure; addr_changed pulses in the cycle reg_addr takes a new value.
module reg_select_ctrl
   import tomasulo_dbg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_RATE     = 10_000_000,
   parameter int NUM_REGS        = NUM_ARCH_REGS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_zero,
   output logic [4:0] reg_addr,
   output logic       addr_changed
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   logic up_lvl, up_rise, dn_lvl, dn_rise, zero_lvl, zero_rise;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .reset(reset), .raw(btn_up), .level(up_lvl), .rise(up_rise)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .reset(reset), .raw(btn_down), .level(dn_lvl), .rise(dn_rise)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
      .clk(clk), .reset(reset), .raw(btn_zero), .level(zero_lvl), .rise(zero_rise)
   );

   sel_state_t       state, state_nxt;
   logic             dir_up, dir_up_nxt;
   logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
   reg_idx_t         addr_nxt;
   logic             held, other, zero_press;

   assign zero_press = zero_rise & zero_lvl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         dir_up       <= 1'b0;
         rpt_cnt      <= '0;
         reg_addr     <= '0;
         addr_changed <= 1'b0;
      end else begin
         state        <= state_nxt;
         dir_up       <= dir_up_nxt;
         rpt_cnt      <= rpt_cnt_nxt;
         reg_addr     <= addr_nxt;
         addr_changed <= (addr_nxt != reg_addr);
      end
   end

   always_comb begin
      state_nxt   = state;
      dir_up_nxt  = dir_up;
      rpt_cnt_nxt = rpt_cnt;
      addr_nxt    = reg_addr;
      held        = dir_up ? up_lvl : dn_lvl;
      other       = dir_up ? dn_lvl : up_lvl;

      if (zero_press) begin
         addr_nxt    = '0;
         state_nxt   = IDLE;
         rpt_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (up_rise && !dn_lvl) begin
                  addr_nxt    = step_idx(reg_addr, 1'b1, NUM_REGS);
                  dir_up_nxt  = 1'b1;
                  rpt_cnt_nxt = '0;
                  state_nxt   = HOLD;
               end else if (dn_rise && !up_lvl) begin
                  addr_nxt    = step_idx(reg_addr, 1'b0, NUM_REGS);
                  dir_up_nxt  = 1'b0;
                  rpt_cnt_nxt = '0;
                  state_nxt   = HOLD;
               end
            end
            HOLD, REPEAT: begin
               // Release or a conflicting direction drops out without stepping.
               if (!held || other) begin
                  state_nxt   = IDLE;
                  rpt_cnt_nxt = '0;
               end else if (rpt_cnt == ((state == HOLD) ? DELAY_LAST : RATE_LAST)) begin
                  addr_nxt    = step_idx(reg_addr, dir_up, NUM_REGS);
                  rpt_cnt_nxt = '0;
                  state_nxt   = REPEAT;
               end else begin
                  rpt_cnt_nxt = rpt_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_select_ctrl.sv
// Directed bench for reg_select_ctrl with short debounce/repeat timing; logs every addr_changed pulse.
module tb_reg_select_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_zero = 1'b0;
   logic [4:0] reg_addr;
   logic       addr_changed;

   always #5 clk = ~clk;

   reg_select_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(16),
      .REPEAT_RATE(4),
      .NUM_REGS(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_zero(btn_zero),
      .reg_addr(reg_addr),
      .addr_changed(addr_changed)
   );

   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         chg_cyc[$];
   int         chg_val[$];
   logic [4:0] prev_addr = 5'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int chg_at(input int k);
      return (k < chg_cyc.size()) ? chg_cyc[k] : -1000;
   endfunction

   function automatic int val_at(input int k);
      return (k < chg_val.size()) ? chg_val[k] : -1;
   endfunction

   // Pulse must coincide exactly with a change of reg_addr.
   always @(negedge clk) begin
      if (!reset) begin
         prev_addr = 5'd0;
      end else if (addr_changed || (reg_addr != prev_addr)) begin
         check("pulse_iff_change", int'(addr_changed), int'(reg_addr != prev_addr));
         if (addr_changed) begin
            chg_cyc.push_back(cyc);
            chg_val.push_back(int'(reg_addr));
         end
         prev_addr = reg_addr;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic u, input logic d, input logic z, input int hold);
      btn_up = u; btn_down = d; btn_zero = z;
      tick(hold);
      btn_up = 1'b0; btn_down = 1'b0; btn_zero = 1'b0;
      tick(14);
   endtask

   typedef struct {
      logic up;
      logic down;
      logic zero;
      int   hold;
      int   exp_addr;
      int   exp_chg;
   } vec_t;

   vec_t vecs[12];
   int   base;
   int   start;

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 10, 2,  1};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 10, 1,  1};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 10, 0,  1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 10, 31, 1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 10, 0,  1};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 10, 0,  0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 10, 0,  0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 10, 31, 1};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 10, 0,  1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 2,  0,  0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 10, 1,  1};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 10, 0,  1};

      reset = 1'b0;
      tick(3);
      check("reset_addr", int'(reg_addr), 0);
      check("reset_pulse", int'(addr_changed), 0);
      reset = 1'b1;
      tick(6);

      // Single press: one step, seven cycles after the raw edge.
      base = chg_cyc.size(); start = cyc;
      btn_up = 1'b1; tick(10); btn_up = 1'b0; tick(14);
      check("press_count", chg_cyc.size() - base, 1);
      check("press_latency", chg_at(base) - start, 7);
      check("press_addr", int'(reg_addr), 1);

      for (int i = 0; i < 12; i++) begin
         base = chg_cyc.size();
         apply(vecs[i].up, vecs[i].down, vecs[i].zero, vecs[i].hold);
         check($sformatf("vec%0d_addr", i), int'(reg_addr), vecs[i].exp_addr);
         check($sformatf("vec%0d_changes", i), chg_cyc.size() - base, vecs[i].exp_chg);
      end

      // Bounce: 2-cycle pulses never survive a 4-cycle debounce.
      base = chg_cyc.size();
      for (int i = 0; i < 5; i++) begin
         btn_up = 1'b1; tick(2);
         btn_up = 1'b0; tick(2);
      end
      tick(14);
      check("bounce_addr", int'(reg_addr), 0);
      check("bounce_changes", chg_cyc.size() - base, 0);

      // Auto-repeat from 5: steps at +7, +23, then every 4 until release is seen.
      for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 10);
      check("setup_five", int'(reg_addr), 5);
      base = chg_cyc.size(); start = cyc;
      btn_up = 1'b1; tick(40); btn_up = 1'b0; tick(14);
      check("rpt_first_latency", chg_at(base) - start, 7);
      check("rpt_first_val", val_at(base), 6);
      check("rpt_delay", chg_at(base + 1) - chg_at(base), 16);
      check("rpt_second_val", val_at(base + 1), 7);
      check("rpt_rate_a", chg_at(base + 2) - chg_at(base + 1), 4);
      check("rpt_third_val", val_at(base + 2), 8);
      check("rpt_rate_b", chg_at(base + 3) - chg_at(base + 2), 4);
      check("rpt_fourth_val", val_at(base + 3), 9);
      check("rpt_changes", chg_cyc.size() - base, 7);
      check("rpt_final", int'(reg_addr), 12);

      // Down repeating, then up joins: stepping freezes at 8.
      base = chg_cyc.size();
      btn_down = 1'b1; tick(28);
      btn_up = 1'b1; tick(32);
      btn_up = 1'b0; btn_down = 1'b0; tick(14);
      check("conflict_changes", chg_cyc.size() - base, 4);
      check("conflict_final", int'(reg_addr), 8);

      // Zero while holding down at 9: clears, then no repeat until re-press.
      apply(1'b1, 1'b0, 1'b0, 10);
      apply(1'b1, 1'b0, 1'b0, 10);
      base = chg_cyc.size(); start = cyc;
      btn_down = 1'b1; tick(10);
      btn_zero = 1'b1; tick(10);
      btn_zero = 1'b0; tick(40);
      btn_down = 1'b0; tick(14);
      check("zero_hold_first", val_at(base), 9);
      check("zero_hold_clear", val_at(base + 1), 0);
      check("zero_hold_latency", chg_at(base + 1) - start, 17);
      check("zero_hold_changes", chg_cyc.size() - base, 2);
      apply(1'b0, 1'b1, 1'b0, 10);
      check("zero_repress_down", int'(reg_addr), 31);

      // Reset mid-hold with up still held: no step until release and re-press.
      apply(1'b0, 1'b0, 1'b1, 10);
      btn_up = 1'b1; tick(30);
      check("midhold_pre_reset", int'(reg_addr), 3);
      reset = 1'b0; #1;
      check("midhold_async_clear", int'(reg_addr), 0);
      tick(3);
      reset = 1'b1;
      base = chg_cyc.size();
      tick(30);
      check("midhold_held_addr", int'(reg_addr), 0);
      check("midhold_held_changes", chg_cyc.size() - base, 0);
      btn_up = 1'b0; tick(14);
      check("midhold_release_addr", int'(reg_addr), 0);
      apply(1'b1, 1'b0, 1'b0, 10);
      check("midhold_repress", int'(reg_addr), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_select_ctrl.md
Name: reg_select_ctrl

Overview:
- Converts three raw board push-buttons (up, down, zero) into the 5-bit register index consumed by the two-digit seven-segment display stage and the register-file debug read port.
- Each button is synchronised and debounced.
- A press steps the index by one, with wrap-around.
- Holding up or down auto-repeats after an initial delay.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: cycles a direction button must be held after the first step before auto-repeat starts.
- REPEAT_RATE, 10_000_000: cycles between steps while auto-repeating.
- NUM_REGS, 32: index range; reg_addr counts 0..NUM_REGS-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn_up  input  1  raw up button, asynchronous, active-high.
- btn_down  input  1  raw down button, asynchronous, active-high.
- btn_zero  input  1  raw clear button, asynchronous, active-high.
- reg_addr  output  5  selected register index; drives the display stage and the debug read port.
- addr_changed  output  1  one-cycle pulse in the same cycle reg_addr takes a new value.

Behaviour:
- Interface: reset is asynchronous, active-low; clock is clk.
- Reset values while reset is low:
  - reg_addr = 0, addr_changed = 0.
  - FSM = IDLE.
  - All synchroniser flops, debounce counters and debounced levels = 0.
  - Repeat counter = 0.
- Reset deasserting mid-hold: a button still held does not step until it is released and pressed again, because the debounced level restarts at 0 and must first rise.
- Synchronisation: each raw button passes through a 2-flop synchroniser.
- Debounce, per button:
  - The counter increments each cycle the synchronised input differs from the debounced level.
  - The counter clears on any cycle they are equal.
  - When a mismatch persists at count DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
- Edge detection: a rising edge of a debounced level is a one-cycle "press" strobe.
- Latency: reg_addr updates on the clk edge after the press strobe. Total latency from a clean raw edge is DEBOUNCE_CYCLES+3 cycles, +1 for sampling phase.
- Step arithmetic:
  - Up: reg_addr = (reg_addr == NUM_REGS-1) ? 0 : reg_addr+1.
  - Down: reg_addr = (reg_addr == 0) ? NUM_REGS-1 : reg_addr-1.
- Zero press: reg_addr <= 0 and FSM <= IDLE.
  - Zero has priority over any step in the same cycle.
  - Zero never auto-repeats.
- addr_changed asserts only when the value actually changes. Zero pressed with reg_addr already 0 gives no pulse.
- FSM states: IDLE, HOLD, REPEAT.
- IDLE:
  - Press of exactly one of up/down, with the other's debounced level low → step once, load repeat counter, go to HOLD with that direction latched.
  - Both pressed in the same cycle → no step, stay IDLE.
- HOLD:
  - Latched button debounced low → IDLE.
  - Other direction's debounced level goes high → IDLE, no step.
  - Counter reaches REPEAT_DELAY-1 → step, clear counter, go to REPEAT.
- REPEAT:
  - Same exit conditions as HOLD.
  - Every REPEAT_RATE cycles → step.
- Release never causes a step. After an exit caused by both buttons being held, a fresh rising edge is required to step again.
- The repeat counter is sized for max(REPEAT_DELAY, REPEAT_RATE). The debounce counter is sized for DEBOUNCE_CYCLES.

Decomposition:
- Shared package (tomasulo_dbg_pkg) holds:
  - typedef reg_idx_t (logic [4:0]).
  - localparam NUM_ARCH_REGS = 32.
  - enum sel_state_t {IDLE, HOLD, REPEAT}.
  - Display stage and debug port reuse reg_idx_t.
- One sub-module, btn_debounce: synchroniser, debounce counter and rise strobe.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, reset, raw, level, rise.
  - Instantiated three times.
- Step/repeat FSM lives in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4.
1. Reset then a single up press held 10 cycles → reg_addr 0→1 exactly once at cycle 7 or 8 after the raw edge, with one addr_changed pulse.
2. Bounce: btn_up toggles every 2 cycles for 20 cycles then goes low → reg_addr stays 0, no addr_changed.
3. Wrap: from reg_addr=31 press up → 0. From 0 press down → 31.
4. Auto-repeat: hold up 40 cycles from reg_addr=5 → steps to 6 at press, 7 after +16, then 8 and 9 every 4 cycles. Release → no further change.
5. Conflict/priority:
   - Hold down and press up while in REPEAT → stepping stops, reg_addr frozen.
   - Press zero at reg_addr=9 while holding down → reg_addr=0 next cycle; no repeat until down is re-pressed.
6. Reset mid-hold: hold up into REPEAT, pulse reset low 3 cycles with btn_up still high → reg_addr=0 and it stays 0 until btn_up is released and pressed again.
